// File: rtl/pc_trap_ctrl_if.sv
// CPU-side bus of the PC/trap controller: next-PC in, PC-source select and trap strobes out.
// dbg_irq_pend exposes the pending-interrupt latch for checkers.
interface pc_trap_ctrl_if;
  logic        pc_en;
  logic [31:0] pc_next;
  logic [2:0]  pc_src_dec;
  logic        undef_inst;
  logic        irq_in;
  logic [31:0] pc;
  logic [2:0]  pc_src;
  logic        kernel;
  logic        inst_kill;
  logic        epc_wr;
  logic [31:0] epc_data;
  logic        irq_ack;
  logic        dbg_irq_pend;

  // master: datapath/decoder side driving the controller; slave: the controller itself.
  modport master (
    output pc_en, pc_next, pc_src_dec, undef_inst, irq_in,
    input  pc, pc_src, kernel, inst_kill, epc_wr, epc_data, irq_ack, dbg_irq_pend
  );

  modport slave (
    input  pc_en, pc_next, pc_src_dec, undef_inst, irq_in,
    output pc, pc_src, kernel, inst_kill, epc_wr, epc_data, irq_ack, dbg_irq_pend
  );
endinterface

// File: rtl/pc_trap_ctrl.sv
// PC register plus interrupt/undefined-instruction trap arbitration for the single-cycle CPU.
// Optional macro PC_TRAP_IRQ_SYNC_EN adds a 2-flop synchroniser on irq_in before edge detection.
module pc_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned HOLDOFF  = 1
) (
  input  logic          clk,
  input  logic          reset,
  pc_trap_ctrl_if.slave bus
);

  localparam int unsigned   HW         = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLDOFF_LD = HW'(HOLDOFF);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [2:0]    SRC_IRQ    = 3'b100;
  localparam logic [2:0]    SRC_EXC    = 3'b101;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0,
    TRAP_EXC  = 2'd1,
    TRAP_IRQ  = 2'd2
  } trap_e;

  logic [31:0] r_pc;
  logic        r_irq_pend;
  logic [HW-1:0] r_holdoff;
  logic        r_irq_prev;
  logic        r_irq_ack;

  logic        w_irq_seen;
  logic        w_irq_edge;
  logic        w_kernel;
  logic        w_take_irq;
  trap_e       w_trap;
  logic [31:0] w_pc_plus4;
  logic [2:0]  w_pc_src;
  logic        w_kill;
  logic        w_epc_wr;
  logic [31:0] w_epc_data;

`ifdef PC_TRAP_IRQ_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_seen = r_sync2;
`else
  assign w_irq_seen = bus.irq_in;
`endif

  assign w_kernel   = r_pc[31];
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_irq_edge = w_irq_seen & ~r_irq_prev;

  // Exception outranks interrupt; nothing traps while already in kernel space.
  always_comb begin
    w_trap = TRAP_NONE;
    if (!w_kernel) begin
      if (bus.undef_inst) begin
        w_trap = TRAP_EXC;
      end else if (r_irq_pend && (r_holdoff == '0)) begin
        w_trap = TRAP_IRQ;
      end
    end
  end

  always_comb begin
    w_pc_src   = bus.pc_src_dec;
    w_kill     = 1'b0;
    w_epc_wr   = 1'b0;
    w_epc_data = 32'd0;
    case (w_trap)
      TRAP_EXC: begin
        w_pc_src   = SRC_EXC;
        w_kill     = 1'b1;
        w_epc_wr   = bus.pc_en;
        w_epc_data = w_pc_plus4;
      end
      TRAP_IRQ: begin
        w_pc_src   = SRC_IRQ;
        w_kill     = 1'b1;
        w_epc_wr   = bus.pc_en;
        w_epc_data = r_pc;
      end
      default: begin
      end
    endcase
  end

  assign w_take_irq = (w_trap == TRAP_IRQ) && bus.pc_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (bus.pc_en) begin
      r_pc <= bus.pc_next & 32'hFFFF_FFFC;
    end
  end

  // Edge detection runs during stalls too, so an IRQ arriving under pc_en = 0 is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_irq_prev <= w_irq_seen;
      if (w_take_irq) begin
        r_irq_pend <= 1'b0;
      end else if (w_irq_edge) begin
        r_irq_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_holdoff <= HOLDOFF_LD;
    end else if (w_kernel) begin
      r_holdoff <= HOLDOFF_LD;
    end else if (bus.pc_en && (r_holdoff != '0)) begin
      r_holdoff <= r_holdoff - HOLD_ONE;
    end
  end

  // Acknowledge lands in the same cycle the PC shows the IRQ vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_ack <= 1'b0;
    end else begin
      r_irq_ack <= w_take_irq;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_src       = w_pc_src;
  assign bus.kernel       = w_kernel;
  assign bus.inst_kill    = w_kill;
  assign bus.epc_wr       = w_epc_wr;
  assign bus.epc_data     = w_epc_data;
  assign bus.irq_ack      = r_irq_ack;
  assign bus.dbg_irq_pend = r_irq_pend;

endmodule

// File: tb/tb_pc_trap_ctrl.sv
// Bench for pc_trap_ctrl: directed trap scenarios followed by randomized traffic,
// compared every cycle against a behavioural model of the PC/trap rules.
module tb_pc_trap_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          HOLDOFF  = 1;
`ifdef PC_TRAP_IRQ_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_trap_ctrl_if bus();
  logic [31:0] tgt;

  pc_trap_ctrl #(
    .RESET_PC(RESET_PC),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Next-PC adder environment: vectors are fixed, branch/jump/register targets come from tgt.
  function automatic logic [31:0] adder(input logic [2:0] src, input logic [31:0] pc,
                                        input logic [31:0] t);
    case (src)
      3'b000:  return pc + 32'd4;
      3'b100:  return 32'h8000_0004;
      3'b101:  return 32'h8000_0008;
      default: return t;
    endcase
  endfunction

  always_comb bus.pc_next = adder(bus.pc_src, bus.pc, tgt);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_retired;
  bit          m_ack;
  bit          m_prev_seen;
  bit          irq_q[$];

  task automatic model_reset();
    m_pc        = RESET_PC;
    m_pend      = 1'b0;
    m_retired   = 0;
    m_ack       = 1'b0;
    m_prev_seen = 1'b0;
    irq_q.delete();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset           = 1'b1;
    bus.pc_en       = 1'b1;
    bus.pc_src_dec  = 3'b000;
    bus.undef_inst  = 1'b0;
    bus.irq_in      = 1'b0;
    tgt             = 32'd0;
    #1;
    model_reset();
    check_eq("rst_pc", bus.pc, RESET_PC);
    check_eq("rst_kernel", {31'd0, bus.kernel}, 32'd1);
    check_eq("rst_irq_ack", {31'd0, bus.irq_ack}, 32'd0);
    check_eq("rst_inst_kill", {31'd0, bus.inst_kill}, 32'd0);
    check_eq("rst_epc_wr", {31'd0, bus.epc_wr}, 32'd0);
    check_eq("rst_irq_pend", {31'd0, bus.dbg_irq_pend}, 32'd0);
    check_eq("rst_pc_src", {29'd0, bus.pc_src}, {29'd0, bus.pc_src_dec});
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; applies one cycle of inputs, checks, then advances the model.
  task automatic drive_cycle(input logic en, input logic [2:0] dec, input logic und,
                             input logic irq, input logic [31:0] t);
    logic        kern, exc, take_irq, seen, edge_seen;
    logic [2:0]  exp_src;
    logic [31:0] exp_pc;
    bus.pc_en      = en;
    bus.pc_src_dec = dec;
    bus.undef_inst = und;
    bus.irq_in     = irq;
    tgt            = t;
    #1;
    kern     = m_pc[31];
    exc      = !kern && und;
    take_irq = !kern && !und && m_pend && (m_retired >= HOLDOFF);
    exp_src  = exc ? 3'b101 : (take_irq ? 3'b100 : dec);

    if (exp_q.size() == 0) begin
      check_eq("pc_queue_empty", 32'd1, 32'd0);
    end else begin
      exp_pc = exp_q.pop_front();
      check_eq("pc", bus.pc, exp_pc);
    end
    check_eq("kernel", {31'd0, bus.kernel}, {31'd0, kern});
    check_eq("pc_src", {29'd0, bus.pc_src}, {29'd0, exp_src});
    check_eq("inst_kill", {31'd0, bus.inst_kill}, {31'd0, exc | take_irq});
    check_eq("epc_wr", {31'd0, bus.epc_wr}, {31'd0, (exc | take_irq) & en});
    if (exc)      check_eq("epc_data_exc", bus.epc_data, m_pc + 32'd4);
    if (take_irq) check_eq("epc_data_irq", bus.epc_data, m_pc);
    check_eq("irq_ack", {31'd0, bus.irq_ack}, {31'd0, m_ack});
    check_eq("irq_pend", {31'd0, bus.dbg_irq_pend}, {31'd0, m_pend});

    @(posedge clk);
    irq_q.push_back(irq);
    seen        = (irq_q.size() > SYNC_DEPTH) ? irq_q.pop_front() : 1'b0;
    edge_seen   = seen && !m_prev_seen;
    m_prev_seen = seen;
    m_ack       = take_irq && en;
    if (take_irq && en) m_pend = 1'b0;
    else if (edge_seen) m_pend = 1'b1;
    if (kern) m_retired = 0;
    else if (en && m_retired < 1000) m_retired++;
    if (en) m_pc = adder(exp_src, m_pc, t) & 32'hFFFF_FFFC;
    exp_q.push_back(m_pc);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        irq_lvl;
    logic [2:0]  dec;
    logic [31:0] t;
    int          r;
    reset = 1'b1;
    tgt   = 32'd0;
    @(negedge clk);
    do_reset();

    repeat (3) drive_cycle(1, 3'b000, 0, 0, 32'd0);
    check_eq("boot_seq", bus.pc, 32'h8000_000C);

    // IRQ in user mode
    drive_cycle(1, 3'b010, 0, 0, 32'h0000_0100);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    repeat (6) drive_cycle(1, 3'b000, 0, 1, 32'd0);
    check_eq("irq_cleared", {31'd0, bus.dbg_irq_pend}, 32'd0);

    // Exception in user mode
    drive_cycle(1, 3'b010, 0, 0, 32'h0000_0200);
    drive_cycle(1, 3'b000, 1, 0, 32'd0);
    check_eq("exc_vec", bus.pc, 32'h8000_0008);

    // IRQ edge under kernel masking, then exception and IRQ together
    repeat (5) drive_cycle(1, 3'b000, 0, 1, 32'd0);
    check_eq("kernel_mask_pend", {31'd0, bus.dbg_irq_pend}, 32'd1);
    drive_cycle(1, 3'b010, 0, 1, 32'h0000_0300);
    drive_cycle(1, 3'b000, 1, 1, 32'd0);
    check_eq("simul_exc_vec", bus.pc, 32'h8000_0008);
    check_eq("simul_pend_kept", {31'd0, bus.dbg_irq_pend}, 32'd1);
    drive_cycle(1, 3'b010, 0, 1, 32'h0000_0304);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    check_eq("simul_irq_vec", bus.pc, 32'h8000_0004);

    // Stall while an IRQ is eligible
    repeat (3) drive_cycle(1, 3'b000, 0, 0, 32'd0);
    repeat (4) drive_cycle(1, 3'b000, 0, 1, 32'd0);
    drive_cycle(1, 3'b010, 0, 1, 32'h0000_0400);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    repeat (3) drive_cycle(0, 3'b000, 0, 1, 32'd0);
    check_eq("stall_pc", bus.pc, 32'h0000_0404);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    check_eq("stall_irq_vec", bus.pc, 32'h8000_0004);
    check_eq("stall_irq_ack", {31'd0, bus.irq_ack}, 32'd1);

    // Reset while an IRQ is about to be taken
    repeat (3) drive_cycle(1, 3'b000, 0, 0, 32'd0);
    repeat (4) drive_cycle(1, 3'b000, 0, 1, 32'd0);
    drive_cycle(1, 3'b010, 0, 1, 32'h0000_0500);
    drive_cycle(1, 3'b000, 0, 1, 32'd0);
    drive_cycle(0, 3'b000, 0, 1, 32'd0);
    do_reset();

    // Misaligned jump target is truncated
    drive_cycle(1, 3'b010, 0, 0, 32'h0000_0603);
    check_eq("align", bus.pc, 32'h0000_0600);

    // Randomized traffic
    irq_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      r   = $urandom_range(0, 15);
      dec = (r < 10) ? 3'b000 : (r < 12) ? 3'b001 : (r < 14) ? 3'b010 : 3'b011;
      t   = $urandom();
      t[31] = m_pc[31] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) irq_lvl = ~irq_lvl;
      drive_cycle($urandom_range(0, 9) < 8, dec, $urandom_range(0, 19) == 0, irq_lvl, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
